vid_timing_tracker: RTL and testbench



---
 rtl/vid_fx_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 24 ++
 rtl/vid_timing_tracker.sv | 123 ++++++++++++
 tb/tb_vid_timing_tracker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vid_fx_pkg.sv
// rtl/vid_fx_pkg.sv - shared pixel word, channel slices and default counter widths for the video FX chain
package vid_fx_pkg;

    localparam int PIX_W  = 24;
    localparam int R_LSB  = 0;
    localparam int G_LSB  = 8;
    localparam int B_LSB  = 16;
    localparam int DEF_HW = 12;
    localparam int DEF_VW = 11;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-stage sync register with rising-edge pulse between the stages
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

    assign rise = s1 & ~q;

endmodule

// File: rtl/vid_timing_tracker.sv
// rtl/vid_timing_tracker.sv - aligns pixel/sync data and tracks position, line length, frame height and lock
module vid_timing_tracker
    import vid_fx_pkg::*;
#(
    parameter int HW          = DEF_HW,
    parameter int VW          = DEF_VW,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          pixclk,
    input  logic          rst_n,
    input  logic [23:0]   vid_pData_in,
    input  logic          hs,
    input  logic          vs,
    output logic [23:0]   vid_pData_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output logic          line_odd,
    output logic [HW-1:0] line_len,
    output logic [VW-1:0] frame_lines,
    output logic          locked
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    pixel_t          pix_s1;
    pixel_t          pix_s2;
    logic            hs_rise;
    logic            vs_rise;
    logic            h_sat;
    logic            v_sat;
    logic [HW:0]     len_wide;
    logic [HW-1:0]   len_next;
    logic [HW-1:0]   prev_len;
    logic [VW-1:0]   prev_lines;
    logic            prev_valid;
    logic [3:0]      stable_cnt;
    logic            match;

    sync_edge_det u_hs_det (
        .clk  (pixclk),
        .rst_n(rst_n),
        .d    (hs),
        .q    (hs_out),
        .rise (hs_rise)
    );

    sync_edge_det u_vs_det (
        .clk  (pixclk),
        .rst_n(rst_n),
        .d    (vs),
        .q    (vs_out),
        .rise (vs_rise)
    );

    assign h_sat    = (h_count == {HW{1'b1}});
    assign v_sat    = (v_count == {VW{1'b1}});
    assign len_wide = (HW+1)'(h_count) + (HW+1)'(1);
    assign len_next = len_wide[HW] ? {HW{1'b1}} : len_wide[HW-1:0];
    assign match    = prev_valid && (v_count == prev_lines) && (line_len == prev_len);

    assign vid_pData_out = pix_s2;
    assign line_odd      = v_count[0];

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_s1      <= '0;
            pix_s2      <= '0;
            h_count     <= '0;
            v_count     <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            prev_len    <= '0;
            prev_lines  <= '0;
            prev_valid  <= 1'b0;
            stable_cnt  <= '0;
            locked      <= 1'b0;
        end else begin
            pix_s1 <= vid_pData_in;
            pix_s2 <= pix_s1;

            if (hs_rise) begin
                h_count  <= '0;
                line_len <= len_next;
            end else if (!h_sat) begin
                h_count <= h_count + 1'b1;
            end

            if (vs_rise) begin
                v_count     <= '0;
                frame_lines <= v_count;
            end else if (hs_rise && !v_sat) begin
                v_count <= v_count + 1'b1;
            end

            if (vs_rise) begin
                prev_lines <= v_count;
                prev_len   <= line_len;
                prev_valid <= 1'b1;
            end

            // A saturated counter means the timing has been lost, regardless of frame edges
            if (h_sat || v_sat) begin
                stable_cnt <= '0;
                locked     <= 1'b0;
            end else if (vs_rise) begin
                if (match) begin
                    if (stable_cnt < LOCK_N) begin
                        stable_cnt <= stable_cnt + 4'd1;
                        if (stable_cnt + 4'd1 == LOCK_N) begin
                            locked <= 1'b1;
                        end
                    end
                end else begin
                    stable_cnt <= '0;
                    locked     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_tracker.sv
// tb/tb_vid_timing_tracker.sv - directed self-checking bench for vid_timing_tracker
module tb_vid_timing_tracker;

    logic        pixclk = 1'b0;
    logic        rst_n;
    logic [23:0] vid_pData_in;
    logic        hs;
    logic        vs;

    logic [23:0] pdata_out;
    logic        hs_out;
    logic        vs_out;
    logic [11:0] h_count;
    logic [10:0] v_count;
    logic        line_odd;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic        locked;

    logic [23:0] s_pdata_out;
    logic        s_hs_out;
    logic        s_vs_out;
    logic [3:0]  s_h_count;
    logic [10:0] s_v_count;
    logic        s_line_odd;
    logic [3:0]  s_line_len;
    logic [10:0] s_frame_lines;
    logic        s_locked;

    int          checks   = 0;
    int          failures = 0;
    int          hist_n   = 0;
    logic [23:0] prev_d;
    logic        prev_h;
    logic        prev_v;

    vid_timing_tracker #(.HW(12), .VW(11), .LOCK_FRAMES(2)) dut (
        .pixclk       (pixclk),
        .rst_n        (rst_n),
        .vid_pData_in (vid_pData_in),
        .hs           (hs),
        .vs           (vs),
        .vid_pData_out(pdata_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .h_count      (h_count),
        .v_count      (v_count),
        .line_odd     (line_odd),
        .line_len     (line_len),
        .frame_lines  (frame_lines),
        .locked       (locked)
    );

    vid_timing_tracker #(.HW(4), .VW(11), .LOCK_FRAMES(2)) dut_s (
        .pixclk       (pixclk),
        .rst_n        (rst_n),
        .vid_pData_in (vid_pData_in),
        .hs           (hs),
        .vs           (vs),
        .vid_pData_out(s_pdata_out),
        .hs_out       (s_hs_out),
        .vs_out       (s_vs_out),
        .h_count      (s_h_count),
        .v_count      (s_v_count),
        .line_odd     (s_line_odd),
        .line_len     (s_line_len),
        .frame_lines  (s_frame_lines),
        .locked       (s_locked)
    );

    always #5 pixclk = ~pixclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [23:0] d, input logic h, input logic v);
        vid_pData_in = d;
        hs           = h;
        vs           = v;
        @(negedge pixclk);
        if (hist_n > 0) begin
            chk("pipe_data", 32'(pdata_out), 32'(prev_d));
            chk("pipe_sync", 32'({hs_out, vs_out}), 32'({prev_h, prev_v}));
        end
        prev_d = d;
        prev_h = h;
        prev_v = v;
        hist_n++;
    endtask

    task automatic run_line(input int len, input int vs_at);
        int hsw;
        hsw = (len > 20) ? 4 : 2;
        for (int c = 0; c < len; c++)
            step(24'($urandom()), c < hsw, (vs_at >= 0) && (c >= vs_at) && (c < vs_at + 2));
    endtask

    task automatic run_frame(input int plen, input int nlines, input int odd_line, input int odd_len);
        for (int j = 0; j < nlines; j++)
            run_line((j == odd_line) ? odd_len : plen, (j == nlines - 1) ? plen / 2 : -1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pdata"}, 32'(pdata_out), 32'h0);
        chk({tag, "_syncs"}, 32'({hs_out, vs_out}), 32'h0);
        chk({tag, "_hcount"}, 32'(h_count), 32'h0);
        chk({tag, "_vcount"}, 32'(v_count), 32'h0);
        chk({tag, "_line_odd"}, 32'(line_odd), 32'h0);
        chk({tag, "_line_len"}, 32'(line_len), 32'h0);
        chk({tag, "_frame_lines"}, 32'(frame_lines), 32'h0);
        chk({tag, "_locked"}, 32'(locked), 32'h0);
        chk({tag, "_s_hcount"}, 32'(s_h_count), 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        hs           = 1'b0;
        vs           = 1'b0;
        vid_pData_in = '0;
        #23;
        check_zero("reset");
        @(negedge pixclk);
        rst_n = 1'b1;

        // Pixel ramp with no syncs: 2-cycle data latency and free-running h_count
        for (int i = 1; i <= 8; i++) begin
            step(24'(i), 1'b0, 1'b0);
            chk("ramp_hcount", 32'(h_count), 32'(i));
        end

        // First 100x10 frame, vs rising mid-way through line 9
        for (int j = 0; j < 10; j++) begin
            run_line(100, (j == 9) ? 50 : -1);
            if (j < 9) begin
                chk("f1_vcount", 32'(v_count), 32'(j + 1));
                chk("f1_line_odd", 32'(line_odd), 32'((j + 1) % 2));
            end
            if (j >= 1)
                chk("f1_line_len", 32'(line_len), 32'd100);
        end
        chk("f1_frame_lines", 32'(frame_lines), 32'd10);
        chk("f1_vcount_after_vs", 32'(v_count), 32'd0);
        chk("f1_locked", 32'(locked), 32'd0);

        run_frame(100, 10, -1, 0);
        chk("f2_frame_lines", 32'(frame_lines), 32'd10);
        chk("f2_locked", 32'(locked), 32'd0);

        run_frame(100, 10, -1, 0);
        chk("f3_locked", 32'(locked), 32'd1);

        // Line 8 is 101 pixels: the line length seen at the next vs_rise breaks lock
        run_frame(100, 10, 8, 101);
        chk("bad_line_len", 32'(line_len), 32'd101);
        chk("bad_locked", 32'(locked), 32'd0);
        run_frame(100, 10, -1, 0);
        chk("c1_locked", 32'(locked), 32'd0);
        run_frame(100, 10, -1, 0);
        run_frame(100, 10, -1, 0);
        chk("c3_locked", 32'(locked), 32'd1);

        // hs and vs rising together after 5 lines
        for (int j = 0; j < 5; j++)
            run_line(100, -1);
        chk("pre_sim_vcount", 32'(v_count), 32'd5);
        step(24'($urandom()), 1'b1, 1'b1);
        step(24'($urandom()), 1'b1, 1'b1);
        chk("sim_hcount", 32'(h_count), 32'd0);
        chk("sim_vcount", 32'(v_count), 32'd0);
        chk("sim_frame_lines", 32'(frame_lines), 32'd5);
        chk("sim_line_len", 32'(line_len), 32'd100);
        chk("sim_locked", 32'(locked), 32'd0);
        for (int c = 2; c < 37; c++)
            step(24'($urandom()), c < 4, 1'b0);

        // Asynchronous reset mid-line, between clock edges
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        hist_n = 0;
        @(negedge pixclk);
        rst_n = 1'b1;

        // Short 10x4 timing that both widths can lock to
        run_frame(10, 4, -1, 0);
        chk("sh1_s_frame_lines", 32'(s_frame_lines), 32'd4);
        run_frame(10, 4, -1, 0);
        chk("sh2_s_locked", 32'(s_locked), 32'd0);
        run_frame(10, 4, -1, 0);
        chk("sh3_locked", 32'(locked), 32'd1);
        chk("sh3_s_locked", 32'(s_locked), 32'd1);
        chk("sh3_line_len", 32'(line_len), 32'd10);
        chk("sh3_s_line_len", 32'(s_line_len), 32'd10);

        // No hs for 20 cycles: the 4-bit counter sticks at 15 and drops lock
        for (int c = 0; c < 20; c++)
            step(24'($urandom()), 1'b0, 1'b0);
        chk("sat_s_hcount", 32'(s_h_count), 32'd15);
        chk("sat_s_locked", 32'(s_locked), 32'd0);
        chk("nosat_hcount", 32'(h_count), 32'd28);
        chk("nosat_locked", 32'(locked), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
